// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for the SRAM arbiter: video read port, CPU read/write port
// and ROM loader write port, each a level request held until its one-cycle ack.
interface sram_arbiter_if #(
    parameter int unsigned AW = 21,
    parameter int unsigned DW = 8
);
    logic          vidReq;
    logic [AW-1:0] vidA;
    logic [DW-1:0] vidDo;
    logic          vidAck;

    logic          cpuReq;
    logic          cpuWe;
    logic [AW-1:0] cpuA;
    logic [DW-1:0] cpuDi;
    logic [DW-1:0] cpuDo;
    logic          cpuAck;

    logic          ldrReq;
    logic [AW-1:0] ldrA;
    logic [DW-1:0] ldrDi;
    logic          ldrAck;

    modport master (
        output vidReq, vidA, cpuReq, cpuWe, cpuA, cpuDi, ldrReq, ldrA, ldrDi,
        input  vidDo, vidAck, cpuDo, cpuAck, ldrAck
    );

    modport slave (
        input  vidReq, vidA, cpuReq, cpuWe, cpuA, cpuDi, ldrReq, ldrA, ldrDi,
        output vidDo, vidAck, cpuDo, cpuAck, ldrAck
    );
endinterface

// File: rtl/sram_arbiter.sv
// Three-way arbiter (video > CPU > loader, with CPU anti-starvation) sharing one
// asynchronous external SRAM; 2-cycle reads, 3-cycle writes with a one-cycle WE pulse.
module sram_arbiter #(
    parameter int unsigned AW   = 21,
    parameter int unsigned DW   = 8,
    parameter int unsigned VMAX = 3
) (
    input  logic          clock,
    input  logic          reset,
    sram_arbiter_if.slave bus,
    output logic          busy,
    output logic          ramWe,
    inout  wire  [DW-1:0] ramD,
    output logic [AW-1:0] ramA
);
    localparam int unsigned VW = $clog2(VMAX + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD1  = 3'd1;
    localparam logic [2:0] RD2  = 3'd2;
    localparam logic [2:0] WR1  = 3'd3;
    localparam logic [2:0] WR2  = 3'd4;
    localparam logic [2:0] WR3  = 3'd5;

    localparam logic [1:0] ID_VID = 2'd0;
    localparam logic [1:0] ID_CPU = 2'd1;
    localparam logic [1:0] ID_LDR = 2'd2;

    logic [2:0]    state_q, state_d;
    logic [1:0]    id_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdat_q;
    logic [VW-1:0] vcnt_q;
    logic          ramwe_q;
    logic          ramd_oe_q;
    logic          vid_ack_q, cpu_ack_q, ldr_ack_q;
    logic [DW-1:0] vid_do_q, cpu_do_q;

    logic          cpu_turn;
    logic          gnt_vid, gnt_cpu, gnt_ldr;

    // Every request level present in IDLE is arbitrated, including the Ack cycle,
    // so a requester holding its level gets back-to-back accesses.
    assign cpu_turn = bus.cpuReq && (vcnt_q == VW'(VMAX));

    always_comb begin
        gnt_vid = 1'b0;
        gnt_cpu = 1'b0;
        gnt_ldr = 1'b0;
        if (state_q == IDLE) begin
            if (bus.vidReq && !cpu_turn) begin
                gnt_vid = 1'b1;
            end else if (bus.cpuReq) begin
                gnt_cpu = 1'b1;
            end else if (bus.ldrReq) begin
                gnt_ldr = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_vid) begin
                    state_d = RD1;
                end else if (gnt_cpu) begin
                    state_d = bus.cpuWe ? WR1 : RD1;
                end else if (gnt_ldr) begin
                    state_d = WR1;
                end
            end
            RD1:     state_d = RD2;
            RD2:     state_d = IDLE;
            WR1:     state_d = WR2;
            WR2:     state_d = WR3;
            WR3:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= ID_VID;
            addr_q    <= '0;
            wdat_q    <= '0;
            vcnt_q    <= '0;
            ramwe_q   <= 1'b1;
            ramd_oe_q <= 1'b0;
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            ldr_ack_q <= 1'b0;
            vid_do_q  <= {DW{1'b1}};
            cpu_do_q  <= {DW{1'b1}};
        end else begin
            state_q <= state_d;
            // Strobe and bus enable are registered from the next state so neither
            // can glitch while the state register changes.
            ramwe_q   <= (state_d != WR2);
            ramd_oe_q <= (state_d == WR1) || (state_d == WR2) || (state_d == WR3);

            if (gnt_vid) begin
                id_q   <= ID_VID;
                addr_q <= bus.vidA;
            end else if (gnt_cpu) begin
                id_q   <= ID_CPU;
                addr_q <= bus.cpuA;
                wdat_q <= bus.cpuDi;
            end else if (gnt_ldr) begin
                id_q   <= ID_LDR;
                addr_q <= bus.ldrA;
                wdat_q <= bus.ldrDi;
            end

            if (!bus.cpuReq || gnt_cpu) begin
                vcnt_q <= '0;
            end else if (gnt_vid && (vcnt_q != VW'(VMAX))) begin
                vcnt_q <= vcnt_q + VW'(1);
            end

            vid_ack_q <= (state_q == RD2) && (id_q == ID_VID);
            cpu_ack_q <= ((state_q == RD2) || (state_q == WR3)) && (id_q == ID_CPU);
            ldr_ack_q <= (state_q == WR3) && (id_q == ID_LDR);

            if (state_q == RD2) begin
                if (id_q == ID_VID) begin
                    vid_do_q <= ramD;
                end else if (id_q == ID_CPU) begin
                    cpu_do_q <= ramD;
                end
            end
        end
    end

    assign ramD = ramd_oe_q ? wdat_q : {DW{1'bz}};
    assign ramA  = addr_q;
    assign ramWe = ramwe_q;
    assign busy  = (state_q != IDLE);

    assign bus.vidAck = vid_ack_q;
    assign bus.cpuAck = cpu_ack_q;
    assign bus.ldrAck = ldr_ack_q;
    assign bus.vidDo  = vid_do_q;
    assign bus.cpuDo  = cpu_do_q;
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: AW, 21, external SRAM address width.
REQ-002 Parameter: DW, 8, external SRAM data width.
REQ-003 Parameter: VMAX, 3, max consecutive video grants while CPU pending.
REQ-004 clock  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vidReq  in  1  video read request; level, held until vidAck.
REQ-007 vidA  in  AW  video read address.
REQ-008 vidDo  out  DW  video read data, valid from vidAck onward.
REQ-009 vidAck  out  1  one-cycle completion pulse, video.
REQ-010 cpuReq  in  1  CPU request; level, held until cpuAck.
REQ-011 cpuWe  in  1  CPU write enable, 1 = write, sampled at grant.
REQ-012 cpuA  in  AW  CPU address.
REQ-013 cpuDi  in  DW  CPU write data.
REQ-014 cpuDo  out  DW  CPU read data, valid from cpuAck onward.
REQ-015 cpuAck  out  1  one-cycle completion pulse, CPU.
REQ-016 ldrReq  in  1  loader write request (ROM image load); level, held until ldrAck.
REQ-017 ldrA  in  AW  loader address.
REQ-018 ldrDi  in  DW  loader write data.
REQ-019 ldrAck  out  1  one-cycle completion pulse, loader.
REQ-020 busy  out  1  1 whenever FSM not in IDLE.
REQ-021 ramWe  out  1  SRAM write strobe, active-low.
REQ-022 ramD  inout  DW  SRAM data bus.
REQ-023 ramA  out  AW  SRAM address.

Function
REQ-024 FSM states SHALL be IDLE, RD1, RD2, WR1, WR2, WR3.
REQ-025 In IDLE, grant SHALL be evaluated every cycle; priority video > CPU > loader, except REQ-026.
REQ-026 Counter vcnt SHALL count consecutive video grants while cpuReq=1; at vcnt=VMAX with cpuReq=1, CPU wins next arbitration; vcnt clears on any CPU grant or when cpuReq=0.
REQ-027 On grant, requester id, address, write flag and write data SHALL be latched; ramA driven from latch in the following cycle and held stable through the access.
REQ-028 Read: IDLE -> RD1 (address out) -> RD2 (sample ramD into requester's Do register at end of RD2) -> IDLE; Ack pulses in the cycle after RD2 (IDLE).
REQ-029 Write: IDLE -> WR1 (address+data out, ramWe=1) -> WR2 (ramWe=0) -> WR3 (ramWe=1, data still driven) -> IDLE; Ack pulses in IDLE cycle after WR3.
REQ-030 Video accesses SHALL always be reads; loader accesses always writes.
REQ-031 Read latency grant-to-ack SHALL be 3 cycles; write 4 cycles.
REQ-032 ramD SHALL be driven only in WR1-WR3; high-impedance in all other states.
REQ-033 ramWe SHALL be 0 only in WR2; never glitch low outside it.
REQ-034 Ack pulse cycle SHALL also be an arbitration cycle; a requester SHALL deassert or present a new request the cycle after its Ack; a level still high two cycles after Ack is a new request.
REQ-035 Simultaneous requests SHALL produce exactly one grant; losers remain pending, no Ack.
REQ-036 Request changes mid-access SHALL not affect the current access (latched values used).
REQ-037 vidDo/cpuDo SHALL hold last read value until next read for that requester; loader never updates them.
REQ-038 busy SHALL be 1 in RD1, RD2, WR1, WR2, WR3.

Reset
REQ-039 While reset=1: state IDLE, ramWe=1, ramD high-Z, ramA=0, all Acks 0, busy 0, vcnt 0, vidDo=cpuDo=8'hFF.
REQ-040 Reset asserted mid-access SHALL abort it next edge with no Ack issued; an aborted write SHALL leave ramWe=1 from that edge.
REQ-041 First arbitration SHALL occur in the first cycle after reset deasserts.

Verification
REQ-042 CPU read cpuA=0x04000, SRAM model returns 0x5A -> cpuAck 3 cycles after grant, cpuDo=0x5A, ramWe stays 1.
REQ-043 Loader write ldrA=0x00010, ldrDi=0xC3 -> ramWe low exactly one cycle (WR2), ramD=0xC3 in WR1-WR3, ldrAck 4 cycles after grant.
REQ-044 vidReq, cpuReq, ldrReq asserted same cycle -> grant order video, CPU, loader; one Ack per access, never two in the same cycle.
REQ-045 vidReq held continuously with cpuReq=1 -> CPU granted after exactly 3 video accesses; vcnt clears.
REQ-046 reset asserted in WR2 of a CPU write -> next cycle ramWe=1, ramD high-Z, no cpuAck; after release CPU request re-granted.
REQ-047 Video read of 0x11 then CPU read of 0x22 -> vidDo remains 0x11 after CPU access.
